// File: rtl/kcpu_pkg.sv
// kcpu_pkg: shared types for the kcpu datapath slice.
//   op_e    - 3-bit micro-op encodings carried on op_code
//   state_e - sequencer states: reset-vector fetch, idle, memory read, memory write
package kcpu_pkg;

    typedef enum logic [2:0] {
        NOP     = 3'd0,
        LDA_IMM = 3'd1,
        TAX     = 3'd2,
        TXA     = 3'd3,
        ADC     = 3'd4,
        LDA_ZX  = 3'd5,
        STA_ZX  = 3'd6,
        LDA_PC  = 3'd7
    } op_e;

    typedef enum logic [2:0] {
        VEC_LO  = 3'd0,
        VEC_HI  = 3'd1,
        VEC_CAP = 3'd2,
        IDLE    = 3'd3,
        RD1     = 3'd4,
        RD2     = 3'd5,
        WR      = 3'd6
    } state_e;

endpackage

// File: rtl/kcpu_idx_regfile.sv
// kcpu_idx_regfile: NUM_IDX x DATA_W index registers.
//   ph0, reset_n      - clock, asynchronous active-low reset (clears all registers)
//   we, wsel, wdata   - synchronous write port
//   rsel, rdata       - combinational read port
// A select value >= NUM_IDX addresses register 0 on both ports.
module kcpu_idx_regfile #(
    parameter int DATA_W  = 8,
    parameter int NUM_IDX = 2,
    localparam int IDX_W  = $clog2(NUM_IDX)
) (
    input  logic              ph0,
    input  logic              reset_n,
    input  logic              we,
    input  logic [IDX_W-1:0]  wsel,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  rsel,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] regs [NUM_IDX];
    logic [IDX_W-1:0]  wsel_m;
    logic [IDX_W-1:0]  rsel_m;

    // Only a non-power-of-two count leaves select codes without a register.
    if (NUM_IDX == (1 << IDX_W)) begin : g_full
        assign wsel_m = wsel;
        assign rsel_m = rsel;
    end else begin : g_clamp
        assign wsel_m = (int'(wsel) < NUM_IDX) ? wsel : '0;
        assign rsel_m = (int'(rsel) < NUM_IDX) ? rsel : '0;
    end

    always_ff @(posedge ph0 or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NUM_IDX; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[wsel_m] <= wdata;
        end
    end

    assign rdata = regs[rsel_m];

endmodule

// File: rtl/kcpu_datapath.sv
// kcpu_datapath: accumulator datapath with carry/zero flags, index registers,
// program counter loaded from a reset vector, and a synchronous-memory port.
//   ph0, reset_n        - clock (rising edge), asynchronous active-low reset
//   op_valid/op_ready   - command handshake; op_ready is high only in IDLE
//   op_code/sel/imm     - micro-op, index register select, immediate
//   mem_addr/wdata/we   - registered memory request; mem_rdata valid one
//                         cycle after the edge that sampled mem_addr
//   acc, carry, zero, pc, running - architectural state
module kcpu_datapath
    import kcpu_pkg::*;
#(
    parameter int                    DATA_W       = 8,
    parameter int                    NUM_IDX      = 2,
    parameter logic [2*DATA_W-1:0]   RESET_VECTOR = (2*DATA_W)'(16'hFFFC),
    localparam int                   ADDR_W       = 2*DATA_W,
    localparam int                   IDX_W        = $clog2(NUM_IDX)
) (
    input  logic              ph0,
    input  logic              reset_n,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [2:0]        op_code,
    input  logic [IDX_W-1:0]  op_sel,
    input  logic [DATA_W-1:0] op_imm,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic [DATA_W-1:0] acc,
    output logic              carry,
    output logic              zero,
    output logic [ADDR_W-1:0] pc,
    output logic              running
);

    state_e            state;
    op_e               op;
    logic              idx_we;
    logic [DATA_W-1:0] idx_rdata;
    logic [DATA_W-1:0] zp_lo;
    logic [DATA_W:0]   adc_sum;

    assign op       = op_e'(op_code);
    assign op_ready = (state == IDLE);
    assign idx_we   = op_valid && op_ready && (op == TAX);

    kcpu_idx_regfile #(
        .DATA_W  (DATA_W),
        .NUM_IDX (NUM_IDX)
    ) u_idx (
        .ph0     (ph0),
        .reset_n (reset_n),
        .we      (idx_we),
        .wsel    (op_sel),
        .wdata   (acc),
        .rsel    (op_sel),
        .rdata   (idx_rdata)
    );

    always_comb begin
        adc_sum = {1'b0, acc} + {1'b0, idx_rdata} + {{DATA_W{1'b0}}, carry};
        zp_lo   = op_imm + idx_rdata;   // wraps inside page 0
    end

    always_ff @(posedge ph0 or negedge reset_n) begin
        if (!reset_n) begin
            state     <= VEC_LO;
            mem_addr  <= RESET_VECTOR;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            acc       <= '0;
            carry     <= 1'b0;
            zero      <= 1'b0;
            pc        <= '0;
            running   <= 1'b0;
        end else begin
            case (state)
                VEC_LO: begin
                    mem_addr <= RESET_VECTOR + ADDR_W'(1);
                    state    <= VEC_HI;
                end
                VEC_HI: begin
                    pc[DATA_W-1:0] <= mem_rdata;
                    state          <= VEC_CAP;
                end
                VEC_CAP: begin
                    pc[ADDR_W-1:DATA_W] <= mem_rdata;
                    running             <= 1'b1;
                    state               <= IDLE;
                end
                IDLE: begin
                    if (op_valid) begin
                        case (op)
                            NOP: ;
                            LDA_IMM: begin
                                acc  <= op_imm;
                                zero <= (op_imm == '0);
                            end
                            TAX: zero <= (acc == '0);
                            TXA: begin
                                acc  <= idx_rdata;
                                zero <= (idx_rdata == '0);
                            end
                            ADC: begin
                                {carry, acc} <= adc_sum;
                                zero         <= (adc_sum[DATA_W-1:0] == '0);
                            end
                            LDA_ZX: begin
                                mem_addr <= {{DATA_W{1'b0}}, zp_lo};
                                state    <= RD1;
                            end
                            STA_ZX: begin
                                mem_addr  <= {{DATA_W{1'b0}}, zp_lo};
                                mem_wdata <= acc;
                                mem_we    <= 1'b1;
                                state     <= WR;
                            end
                            LDA_PC: begin
                                mem_addr <= pc;
                                pc       <= pc + ADDR_W'(1);
                                state    <= RD1;
                            end
                            default: ;
                        endcase
                    end
                end
                // RD1 covers the edge where memory samples mem_addr; the
                // data is captured one edge later in RD2.
                RD1: state <= RD2;
                RD2: begin
                    acc   <= mem_rdata;
                    zero  <= (mem_rdata == '0);
                    state <= IDLE;
                end
                WR: begin
                    mem_we <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= VEC_LO;
            endcase
        end
    end

endmodule
